// File: rtl/brq_pkg.sv
// Shared types for the register-file write arbiter: arbitration state and the
// write-request bundle carried by every producer.
package brq_pkg;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_AGED   = 1'b1
    } rf_arb_state_e;

    typedef struct packed {
        logic        fp;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rf_wr_req_t;

    localparam rf_wr_req_t RfWrReqIdle = '0;

    // x0 is hard-wired zero; an integer write there is consumed but never lands.
    function automatic logic rf_wr_writes_int(input rf_wr_req_t req);
        return !req.fp && (req.waddr != 5'd0);
    endfunction

endpackage

// File: rtl/brq_rf_wr_aging.sv
// Starvation guard for the multicycle unit: counts ID wins over a pending MC
// request and flips arbitration to MC-first once the limit is reached.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ARB_NORMAL | ID wins over MC; wait_q counts MC losses to ID
//   ARB_AGED   | MC wins over ID until it is granted or withdraws its request
module brq_rf_wr_aging
    import brq_pkg::*;
#(
    parameter int unsigned MaxWait = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic mc_valid_i,
    input  logic mc_gnt_i,
    input  logic id_gnt_i,
    output logic aged_o
);

    localparam int unsigned     WaitW   = $clog2(MaxWait + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MaxWait);

    logic [WaitW-1:0] wait_q, wait_d;
    rf_arb_state_e    state_q, state_d;

    // LSU-occupied cycles grant neither ID nor MC, so they leave the count alone.
    always_comb begin
        wait_d = wait_q;
        if (!mc_valid_i || mc_gnt_i) begin
            wait_d = '0;
        end else if (id_gnt_i && (wait_q != WaitMax)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Entering AGED on the edge where the count reaches the limit lets MC win
    // immediately after exactly MaxWait losses.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_NORMAL: if (wait_d == WaitMax)           state_d = ARB_AGED;
            ARB_AGED:   if (mc_gnt_i || !mc_valid_i)     state_d = ARB_NORMAL;
            default:                                     state_d = ARB_NORMAL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q  <= '0;
            state_q <= ARB_NORMAL;
        end else begin
            wait_q  <= wait_d;
            state_q <= state_d;
        end
    end

    assign aged_o = (state_q == ARB_AGED);

endmodule

// File: rtl/brq_rf_wr_arbiter.sv
// Single shared register-file write port: LSU > ID/MC (order set by the aging
// FSM), steered to the integer or FP file, optionally registered for timing.
module brq_rf_wr_arbiter
    import brq_pkg::*;
#(
    parameter int unsigned MaxWait = 4,
    parameter bit          RegOut  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        lsu_we_i,
    input  logic        lsu_fp_i,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,

    input  logic        id_valid_i,
    output logic        id_ready_o,
    input  logic        id_fp_i,
    input  logic [4:0]  id_waddr_i,
    input  logic [31:0] id_wdata_i,

    input  logic        mc_valid_i,
    output logic        mc_ready_o,
    input  logic        mc_fp_i,
    input  logic [4:0]  mc_waddr_i,
    input  logic [31:0] mc_wdata_i,

    output logic        rf_we_o,
    output logic        fp_rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,

    output logic        fwd_valid_o,
    output logic        fwd_fp_o,
    output logic [4:0]  fwd_waddr_o,

    output logic        mc_aged_o
);

    rf_wr_req_t lsu_req, id_req, mc_req, win_req;
    logic       aged;
    logic       id_gnt, mc_gnt;
    logic       win_we, win_int_we, win_fp_we;

    assign lsu_req = '{fp: lsu_fp_i, waddr: lsu_waddr_i, wdata: lsu_wdata_i};
    assign id_req  = '{fp: id_fp_i,  waddr: id_waddr_i,  wdata: id_wdata_i};
    assign mc_req  = '{fp: mc_fp_i,  waddr: mc_waddr_i,  wdata: mc_wdata_i};

    // Readies never look at their own valid, keeping producers free of comb loops.
    assign id_ready_o = ~lsu_we_i & (~mc_valid_i | ~aged);
    assign mc_ready_o = ~lsu_we_i & (aged | ~id_valid_i);

    assign id_gnt = id_valid_i & id_ready_o;
    assign mc_gnt = mc_valid_i & mc_ready_o;

    always_comb begin
        win_req = RfWrReqIdle;
        if (lsu_we_i) begin
            win_req = lsu_req;
        end else if (id_gnt) begin
            win_req = id_req;
        end else if (mc_gnt) begin
            win_req = mc_req;
        end
    end

    assign win_we     = lsu_we_i | id_gnt | mc_gnt;
    assign win_int_we = win_we & rf_wr_writes_int(win_req);
    assign win_fp_we  = win_we & win_req.fp;

    brq_rf_wr_aging #(
        .MaxWait (MaxWait)
    ) u_aging (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .mc_valid_i (mc_valid_i),
        .mc_gnt_i   (mc_gnt),
        .id_gnt_i   (id_gnt),
        .aged_o     (aged)
    );

    assign mc_aged_o = aged;

    if (RegOut) begin : g_reg_out
        logic       int_we_q, fp_we_q;
        rf_wr_req_t req_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                int_we_q <= 1'b0;
                fp_we_q  <= 1'b0;
                req_q    <= RfWrReqIdle;
            end else begin
                int_we_q <= win_int_we;
                fp_we_q  <= win_fp_we;
                req_q    <= win_req;
            end
        end

        assign rf_we_o     = int_we_q;
        assign fp_rf_we_o  = fp_we_q;
        assign rf_waddr_o  = req_q.waddr;
        assign rf_wdata_o  = req_q.wdata;
        // x0 writes never land, so they are not offered for forwarding.
        assign fwd_valid_o = int_we_q | fp_we_q;
        assign fwd_fp_o    = req_q.fp;
        assign fwd_waddr_o = req_q.waddr;
    end else begin : g_comb_out
        assign rf_we_o     = win_int_we;
        assign fp_rf_we_o  = win_fp_we;
        assign rf_waddr_o  = win_req.waddr;
        assign rf_wdata_o  = win_req.wdata;
        assign fwd_valid_o = 1'b0;
        assign fwd_fp_o    = 1'b0;
        assign fwd_waddr_o = 5'd0;
    end

`ifndef SYNTHESIS
    a_mc_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mc_valid_i && !mc_gnt) |=>
            (mc_valid_i && $stable({mc_fp_i, mc_waddr_i, mc_wdata_i})));

    a_lsu_taken: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lsu_we_i |-> (!id_gnt && !mc_gnt && (win_req == lsu_req)));
`endif

endmodule
